// File: rtl/fsk_ask_demod_rx.sv
// fsk_ask_demod_rx: recovers one bit per symbol from 10-bit offset-binary ADC samples of a 2ASK/2FSK carrier.
// Optional macro DEMOD_DBG_EN adds out_metric, the per-symbol decision metric (ASK peak / FSK crossings).
//
// state   | meaning
// IDLE    | waiting for the first valid sample, or demodulator disabled (mode 1x)
// ACCUM   | accumulating peak deviation and rising crossings for the current symbol
// EMIT    | one clock: register the decision; a valid sample here starts the next symbol
module fsk_ask_demod_rx #(
    parameter int DW      = 10,
    parameter int MID     = 512,
    parameter int SYM_LEN = 256,
    parameter int HYST    = 16,
    parameter int ASK_TH  = 128,
    parameter int FSK_TH  = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] in_ad_data,
    input  logic          in_ad_valid,
    output logic          out_bit,
    output logic          out_bit_valid,
`ifdef DEMOD_DBG_EN
    output logic [8:0]    out_metric,
`endif
    output logic          out_busy
);

    localparam int CW = $clog2(SYM_LEN);
    localparam int PW = DW - 1;

    localparam logic [CW-1:0] LAST     = CW'(SYM_LEN - 1);
    localparam logic [DW:0]   MID_X    = (DW+1)'(MID);
    localparam logic [DW:0]   LO_X     = (DW+1)'(MID - HYST);
    localparam logic [DW:0]   HI_X     = (DW+1)'(MID + HYST);
    localparam logic [DW:0]   PMAX_X   = (DW+1)'(2**(DW-1) - 1);
    localparam logic [PW-1:0] ASK_TH_P = PW'(ASK_TH);
    localparam logic [8:0]    FSK_TH_X = 9'(FSK_TH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_EMIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] peak_q, peak_d;
    logic [8:0]    xcnt_q, xcnt_d;
    logic          arm_q, arm_d;
    logic          bit_d, bit_valid_d;
    logic [1:0]    mode_q;

    logic [DW:0]   x_ext;
    logic [DW:0]   dev;
    logic [PW-1:0] dev_sat;
    logic          abort;
    logic          decision;
    logic          clear;
    logic          take;

    // Deviation from midscale is formed one bit wider so x=0 does not wrap before saturation.
    assign x_ext    = {1'b0, in_ad_data};
    assign dev      = (x_ext >= MID_X) ? (x_ext - MID_X) : (MID_X - x_ext);
    assign dev_sat  = (dev > PMAX_X) ? PMAX_X[PW-1:0] : dev[PW-1:0];
    assign abort    = (state_q != S_IDLE) && (mode != mode_q);
    assign decision = (mode_q == 2'b00) ? (peak_q >= ASK_TH_P) : (xcnt_q >= FSK_TH_X);
    assign out_busy = (state_q != S_IDLE);

`ifdef DEMOD_DBG_EN
    logic [8:0] metric_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        peak_d      = peak_q;
        xcnt_d      = xcnt_q;
        arm_d       = arm_q;
        bit_d       = out_bit;
        bit_valid_d = 1'b0;
        clear       = 1'b0;
        take        = 1'b0;
`ifdef DEMOD_DBG_EN
        metric_d    = out_metric;
`endif
        case (state_q)
            S_IDLE: begin
                if (!mode[1] && in_ad_valid) begin
                    clear   = 1'b1;
                    take    = 1'b1;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (abort) begin
                    clear   = 1'b1;
                    arm_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (in_ad_valid) begin
                    take = 1'b1;
                    if (cnt_q == LAST) state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (abort) begin
                    clear   = 1'b1;
                    arm_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    bit_d       = decision;
                    bit_valid_d = 1'b1;
`ifdef DEMOD_DBG_EN
                    metric_d    = (mode_q == 2'b00) ? 9'(peak_q) : xcnt_q;
`endif
                    clear       = 1'b1;
                    take        = in_ad_valid;
                    state_d     = S_ACCUM;
                end
            end
            default: begin
                clear   = 1'b1;
                arm_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (clear) begin
            cnt_d  = '0;
            peak_d = '0;
            xcnt_d = '0;
        end
        // Arm persists across symbol boundaries so a crossing split over two symbols is not lost.
        if (take) begin
            cnt_d = cnt_d + CW'(1);
            if (dev_sat > peak_d) peak_d = dev_sat;
            if (arm_d && (x_ext >= HI_X)) begin
                arm_d = 1'b0;
                if (xcnt_d != 9'h1FF) xcnt_d = xcnt_d + 9'd1;
            end else if (x_ext <= LO_X) begin
                arm_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            peak_q        <= '0;
            xcnt_q        <= '0;
            arm_q         <= 1'b0;
            out_bit       <= 1'b0;
            out_bit_valid <= 1'b0;
            mode_q        <= 2'b00;
`ifdef DEMOD_DBG_EN
            out_metric    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            peak_q        <= peak_d;
            xcnt_q        <= xcnt_d;
            arm_q         <= arm_d;
            out_bit       <= bit_d;
            out_bit_valid <= bit_valid_d;
            mode_q        <= mode;
`ifdef DEMOD_DBG_EN
            out_metric    <= metric_d;
`endif
        end
    end

endmodule
